motor_sequencer: RTL and testbench
==================================

# motor_sequencer

Command sequencer in front of the two-motor PWM driver. It accepts drive commands (mode plus 10-bit duty) over a valid/ready handshake and produces the `mode`/`speed` pair that feeds the motor block. Speed ramps at a fixed slew rate. Any direction change goes through brake-to-zero and a dead-time interval at mode 00, so the H-bridges never see an abrupt reversal. An emergency-stop input overrides everything.

## Interface
- `RAMP_DIV`, 100_000, clk cycles per ramp step (1 ms at 100 MHz); must be ≥1.
- `RAMP_STEP`, 8, duty increment/decrement per step; 1..1023.
- `DEAD_CYCLES`, 1_000_000, cycles held at mode 00/speed 0 between directions; ≥1.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_mode` in 2: requested motor mode (00 = stop).
- `cmd_speed` in 10: requested duty, 0..1023.
- `estop` in 1: level emergency stop.
- `mode` out 2: to motor `mode`; registered.
- `speed` out 10: to motor `speed`; registered.
- `busy` out 1: high in RAMP, BRAKE, DEAD.
- `at_target` out 1: high in IDLE and HOLD.

## Operation
- Reset values: state IDLE, `mode`=00, `speed`=0, targets 00/0, prescaler 0, `cmd_ready`=1, `busy`=0, `at_target`=1.
- `cmd_ready` = (state is IDLE or HOLD) and !`estop`. It is combinational from the state register.
- Priority: `rst` > `estop` > command.
- IDLE:
  - Accepting (00, x) or (x, 0) is consumed and state stays IDLE.
  - Accepting any other command latches the target and goes to RAMP with `mode`=`cmd_mode` and `speed`=0.
- HOLD:
  - Accepting a command with `cmd_mode`==`mode` and `cmd_speed`≠0 goes to RAMP toward the new speed.
  - Any other command (different mode, mode 00, or speed 0) latches the target and goes to BRAKE.
- RAMP:
  - Each ramp tick moves `speed` toward the target.
  - Up step: min(speed+RAMP_STEP, target), computed in 11 bits, so there is no wrap past 1023.
  - Down step: the target if (speed−target) ≤ RAMP_STEP, else speed−RAMP_STEP.
  - The edge that makes `speed`==target also moves the state to HOLD.
  - If RAMP is entered already at target, it goes to HOLD on the next edge with no tick.
- BRAKE:
  - `mode` is unchanged; `speed` ramps down toward 0 using the same rule.
  - The edge that reaches 0 sets `mode`=00 and enters DEAD with the dead counter at 0.
  - If BRAKE is entered with `speed`=0, it goes to DEAD on the next edge.
- DEAD:
  - `mode`=00 and `speed`=0 for exactly DEAD_CYCLES cycles.
  - Then, if the target mode is 00 or the target speed is 0, go to IDLE.
  - Otherwise go to RAMP with `mode`=target mode and `speed`=0.
- `estop` high at an edge:
  - `mode`=00, `speed`=0, targets cleared to 00/0, state DEAD, dead counter 0.
  - Reasserting `estop` keeps restarting the dead counter.
  - After release, the full dead time elapses, then IDLE.
- `rst` mid-operation: IDLE with all reset values on the next edge.

## Timing
- Ramp prescaler:
  - Runs only in RAMP and BRAKE; cleared on every state entry.
  - Tick fires when the prescaler equals RAMP_DIV−1, i.e. the first step lands RAMP_DIV cycles after entry.
- Accept in IDLE at edge N: `mode` valid at N+1. A ramp 0→T reaches HOLD at edge N + ceil(T/RAMP_STEP)·RAMP_DIV.
- Direction change from speed S: BRAKE lasts ceil(S/RAMP_STEP)·RAMP_DIV cycles, DEAD lasts DEAD_CYCLES cycles, then the ramp-up follows.
- `mode` and `speed` never change in the same cycle from one nonzero mode to another. Mode 00 is always held at least DEAD_CYCLES cycles in between.

## Structure
- Package `motor_seq_pkg`:
  - State enum: IDLE, RAMP, BRAKE, DEAD, HOLD.
  - Constants `MODE_STOP`=2'b00 and `SPEED_MAX`=10'd1023.
- One sub-module `ramp_tick`: prescaler with `clear`/`enable` inputs and a `tick` output, parameterised by RAMP_DIV.
- The FSM, dead counter (width from DEAD_CYCLES) and step arithmetic live in `motor_sequencer`.

## Test plan
All scenarios use RAMP_DIV=4, RAMP_STEP=100, DEAD_CYCLES=5.
- Reset: assert `rst` for 2 cycles → `mode`=00, `speed`=0, `cmd_ready`=1, `busy`=0, `at_target`=1.
- Ramp-up from IDLE: cmd (11, 250) → `mode`=11 next cycle; `speed` is 100, 200, 250 at +4, +8, +12 cycles; then HOLD with `at_target`=1.
- Clamp: from HOLD (11, 250), cmd (11, 1023) → speed steps 350…950 then 1023 exactly, with no wrap.
- Reversal: from HOLD (11, 250), cmd (01, 300) → in mode 11, speed 150, 50, 0; then `mode`=00 for exactly 5 cycles; then mode 01 ramps 100, 200, 300.
- E-stop mid-RAMP:
  - Next edge gives `mode`=00, `speed`=0, `cmd_ready`=0.
  - `cmd_valid` is ignored while `estop` is high.
  - 5 cycles after release the state is IDLE with `cmd_ready`=1.
- Reset mid-DEAD: `rst` pulse → IDLE on the next edge, outputs at reset values.

Source files
------------

// File: rtl/motor_seq_pkg.sv
// Shared types, constants and the speed slew helper for the motor command sequencer.
package motor_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        BRAKE,
        DEAD,
        HOLD
    } state_t;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [9:0] SPEED_MAX = 10'd1023;

    // One slew step from cur toward tgt; the up path uses 11 bits so it never wraps past 1023.
    function automatic logic [9:0] step_toward(input logic [9:0] cur,
                                               input logic [9:0] tgt,
                                               input logic [9:0] step);
        logic [10:0] sum;
        logic [9:0]  diff;
        logic [9:0]  result;
        sum    = {1'b0, cur} + {1'b0, step};
        diff   = cur - tgt;
        result = tgt;
        if (cur < tgt) begin
            result = (sum >= {1'b0, tgt}) ? tgt : sum[9:0];
        end else if (diff > step) begin
            result = cur - step;
        end
        return result;
    endfunction

endpackage

// File: rtl/ramp_tick.sv
// Ramp prescaler: emits one tick every RAMP_DIV enabled cycles, restarting from zero on clear.
module ramp_tick #(
    parameter int RAMP_DIV = 100_000
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/motor_sequencer.sv
// Command sequencer feeding the motor PWM driver: slewed speed, brake-then-dead-time on
// every direction change, and an emergency stop that overrides everything.
module motor_sequencer
    import motor_seq_pkg::*;
#(
    parameter int RAMP_DIV    = 100_000,
    parameter int RAMP_STEP   = 8,
    parameter int DEAD_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [9:0] cmd_speed,
    input  logic       estop,
    output logic [1:0] mode,
    output logic [9:0] speed,
    output logic       busy,
    output logic       at_target
);

    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [9:0] STEP = 10'(RAMP_STEP);

    state_t        state;
    logic [1:0]    target_mode;
    logic [9:0]    target_speed;
    logic [DW-1:0] dead_cnt;
    logic          tick;
    logic          ramping;
    logic          accept;
    logic [9:0]    next_speed;

    assign ramping    = (state == RAMP) || (state == BRAKE);
    assign at_target  = (state == IDLE) || (state == HOLD);
    assign busy       = ramping || (state == DEAD);
    assign cmd_ready  = at_target && !estop;
    assign accept     = cmd_valid && cmd_ready;
    assign next_speed = step_toward(speed, (state == BRAKE) ? 10'd0 : target_speed, STEP);

    // The prescaler only counts while slewing, so every entry into RAMP/BRAKE starts a fresh period.
    ramp_tick #(
        .RAMP_DIV(RAMP_DIV)
    ) u_ramp_tick (
        .clk   (clk),
        .clear (rst || !ramping),
        .enable(ramping),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mode         <= MODE_STOP;
            speed        <= '0;
            target_mode  <= MODE_STOP;
            target_speed <= '0;
            dead_cnt     <= '0;
        end else if (estop) begin
            state        <= DEAD;
            mode         <= MODE_STOP;
            speed        <= '0;
            target_mode  <= MODE_STOP;
            target_speed <= '0;
            dead_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && cmd_mode != MODE_STOP && cmd_speed != '0) begin
                        target_mode  <= cmd_mode;
                        target_speed <= cmd_speed;
                        mode         <= cmd_mode;
                        speed        <= '0;
                        state        <= RAMP;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        target_mode  <= cmd_mode;
                        target_speed <= cmd_speed;
                        state        <= (cmd_mode == mode && cmd_speed != '0) ? RAMP : BRAKE;
                    end
                end
                RAMP: begin
                    if (speed == target_speed) begin
                        state <= HOLD;
                    end else if (tick) begin
                        speed <= next_speed;
                        if (next_speed == target_speed) state <= HOLD;
                    end
                end
                BRAKE: begin
                    // Mode is kept until speed reaches zero so the bridge never reverses under load.
                    if (speed == '0 || (tick && next_speed == '0)) begin
                        speed    <= '0;
                        mode     <= MODE_STOP;
                        dead_cnt <= '0;
                        state    <= DEAD;
                    end else if (tick) begin
                        speed <= next_speed;
                    end
                end
                DEAD: begin
                    if (dead_cnt == DEAD_LAST) begin
                        if (target_mode == MODE_STOP || target_speed == '0) begin
                            state <= IDLE;
                        end else begin
                            mode  <= target_mode;
                            speed <= '0;
                            state <= RAMP;
                        end
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_sequencer.sv
// Self-checking bench for motor_sequencer: directed scenarios plus random traffic against a timer-based model.
module tb_motor_sequencer;

    localparam int RAMP_DIV    = 4;
    localparam int RAMP_STEP   = 100;
    localparam int DEAD_CYCLES = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'b00;
    logic [9:0] cmd_speed = 10'd0;
    logic       estop = 1'b0;
    logic [1:0] mode;
    logic [9:0] speed;
    logic       busy;
    logic       at_target;

    int total = 0;
    int bad = 0;
    bit modelOn = 1'b0;

    // Model phases: 0 idle, 1 ramp, 2 brake, 3 dead, 4 hold.
    int mPhase = 0;
    int mMode = 0;
    int mSpeed = 0;
    int tMode = 0;
    int tSpeed = 0;
    int stepWait = 0;
    int deadLeft = 0;

    motor_sequencer #(
        .RAMP_DIV   (RAMP_DIV),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_mode (cmd_mode),
        .cmd_speed(cmd_speed),
        .estop    (estop),
        .mode     (mode),
        .speed    (speed),
        .busy     (busy),
        .at_target(at_target)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input int m, input int s, input bit e, input bit r);
        cmd_valid = v;
        cmd_mode  = 2'(m);
        cmd_speed = 10'(s);
        estop     = e;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Reference behaviour: countdown timers per phase, speeds stepped with min/max arithmetic.
    always @(posedge clk) begin
        if (rst) begin
            mPhase = 0; mMode = 0; mSpeed = 0; tMode = 0; tSpeed = 0;
        end else if (estop) begin
            mPhase = 3; mMode = 0; mSpeed = 0; tMode = 0; tSpeed = 0; deadLeft = DEAD_CYCLES;
        end else begin
            case (mPhase)
                0: if (cmd_valid && cmd_mode != 0 && cmd_speed != 0) begin
                    tMode = cmd_mode; tSpeed = cmd_speed; mMode = cmd_mode; mSpeed = 0;
                    mPhase = 1; stepWait = RAMP_DIV;
                end
                4: if (cmd_valid) begin
                    tMode = cmd_mode; tSpeed = cmd_speed;
                    mPhase = (cmd_mode == mMode && cmd_speed != 0) ? 1 : 2;
                    stepWait = RAMP_DIV;
                end
                1: if (mSpeed == tSpeed) begin
                    mPhase = 4;
                end else begin
                    stepWait--;
                    if (stepWait == 0) begin
                        stepWait = RAMP_DIV;
                        if (mSpeed < tSpeed) mSpeed = (mSpeed + RAMP_STEP > tSpeed) ? tSpeed : mSpeed + RAMP_STEP;
                        else mSpeed = (mSpeed - RAMP_STEP < tSpeed) ? tSpeed : mSpeed - RAMP_STEP;
                        if (mSpeed == tSpeed) mPhase = 4;
                    end
                end
                2: begin
                    if (mSpeed != 0) begin
                        stepWait--;
                        if (stepWait == 0) begin
                            stepWait = RAMP_DIV;
                            mSpeed = (mSpeed > RAMP_STEP) ? mSpeed - RAMP_STEP : 0;
                            if (mSpeed == 0) begin
                                mMode = 0; mPhase = 3; deadLeft = DEAD_CYCLES;
                            end
                        end
                    end else begin
                        mMode = 0; mPhase = 3; deadLeft = DEAD_CYCLES;
                    end
                end
                3: begin
                    deadLeft--;
                    if (deadLeft == 0) begin
                        if (tMode == 0 || tSpeed == 0) begin
                            mPhase = 0;
                        end else begin
                            mMode = tMode; mSpeed = 0; mPhase = 1; stepWait = RAMP_DIV;
                        end
                    end
                end
                default: mPhase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("model mode", int'(mode), mMode);
            checkOutput("model speed", int'(speed), mSpeed);
            checkOutput("model cmd_ready", int'(cmd_ready), int'((mPhase == 0 || mPhase == 4) && !estop));
            checkOutput("model busy", int'(busy), int'(mPhase >= 1 && mPhase <= 3));
            checkOutput("model at_target", int'(at_target), int'(mPhase == 0 || mPhase == 4));
        end
    end

    initial begin
        int estopLeft;
        int pick;
        estopLeft = 0;

        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        checkOutput("reset mode", int'(mode), 0);
        checkOutput("reset speed", int'(speed), 0);
        checkOutput("reset cmd_ready", int'(cmd_ready), 1);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset at_target", int'(at_target), 1);
        modelOn = 1'b1;

        applyStimulus(1'b1, 3, 250, 1'b0, 1'b0);
        checkOutput("ramp mode", int'(mode), 3);
        checkOutput("ramp start speed", int'(speed), 0);
        checkOutput("ramp busy", int'(busy), 1);
        idleCycles(4);  checkOutput("ramp speed +4", int'(speed), 100);
        idleCycles(4);  checkOutput("ramp speed +8", int'(speed), 200);
        idleCycles(4);  checkOutput("ramp speed +12", int'(speed), 250);
        checkOutput("ramp hold at_target", int'(at_target), 1);

        applyStimulus(1'b1, 3, 1023, 1'b0, 1'b0);
        idleCycles(28); checkOutput("clamp speed 950", int'(speed), 950);
        idleCycles(4);  checkOutput("clamp speed 1023", int'(speed), 1023);
        checkOutput("clamp at_target", int'(at_target), 1);
        applyStimulus(1'b1, 3, 250, 1'b0, 1'b0);
        idleCycles(32); checkOutput("slew down speed", int'(speed), 250);

        applyStimulus(1'b1, 1, 300, 1'b0, 1'b0);
        checkOutput("reverse keeps mode", int'(mode), 3);
        idleCycles(4);  checkOutput("brake speed 150", int'(speed), 150);
        checkOutput("brake mode", int'(mode), 3);
        idleCycles(4);  checkOutput("brake speed 50", int'(speed), 50);
        idleCycles(4);  checkOutput("brake zero mode", int'(mode), 0);
        checkOutput("brake zero speed", int'(speed), 0);
        idleCycles(4);  checkOutput("dead mode +4", int'(mode), 0);
        idleCycles(1);  checkOutput("dead exit mode", int'(mode), 1);
        idleCycles(4);  checkOutput("reverse speed 100", int'(speed), 100);
        idleCycles(4);  checkOutput("reverse speed 200", int'(speed), 200);
        idleCycles(4);  checkOutput("reverse speed 300", int'(speed), 300);

        applyStimulus(1'b1, 1, 800, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("estop mode", int'(mode), 0);
        checkOutput("estop speed", int'(speed), 0);
        checkOutput("estop cmd_ready", int'(cmd_ready), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3, 500, 1'b1, 1'b0);
        checkOutput("estop ignores cmd", int'(mode), 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        idleCycles(3);
        checkOutput("estop dead busy", int'(busy), 1);
        checkOutput("estop dead cmd_ready", int'(cmd_ready), 0);
        idleCycles(1);
        checkOutput("estop release cmd_ready", int'(cmd_ready), 1);
        checkOutput("estop release busy", int'(busy), 0);

        applyStimulus(1'b1, 3, 200, 1'b0, 1'b0);
        idleCycles(8);
        applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
        idleCycles(10);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        checkOutput("mid-dead reset mode", int'(mode), 0);
        checkOutput("mid-dead reset cmd_ready", int'(cmd_ready), 1);
        checkOutput("mid-dead reset busy", int'(busy), 0);
        checkOutput("mid-dead reset at_target", int'(at_target), 1);

        for (int c = 0; c < 4000; c++) begin
            bit v, e, r;
            int s;
            r = ($urandom_range(0, 299) == 0);
            if (estopLeft == 0 && $urandom_range(0, 59) == 0) estopLeft = $urandom_range(1, 4);
            e = (estopLeft != 0);
            if (estopLeft != 0) estopLeft--;
            v = ($urandom_range(0, 2) == 0);
            pick = $urandom_range(0, 4);
            case (pick)
                0: s = 0;
                1: s = 1023;
                2: s = $urandom_range(1, 99);
                default: s = $urandom_range(0, 1023);
            endcase
            applyStimulus(v, $urandom_range(0, 3), s, e, r);
        end

        idleCycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
